// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte stream and error pulses between uart_rx and its consumer
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with one-byte output buffer
module uart_rx #(
  parameter int F    = 8000000,
  parameter int BAUD = 115200
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      rx,
  uart_rx_if.master out
);

  localparam int N  = (F + BAUD / 2) / BAUD;
  localparam int H  = N / 2;
  localparam int CW = $clog2(N);

  if (N < 4) begin : g_bad_baud
    $error("uart_rx: bit period below 4 clocks");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t          state_q, state_d;
  logic            rx_m, rx_s;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic [7:0]      data_q;
  logic            valid_q;
  logic            frame_err_q;
  logic            overrun_q;

  logic            half_tick, bit_tick;
  logic            cnt_clr, shift_en, stop_ok, stop_bad;

  assign half_tick = (cnt_q == CW'(H - 1));
  assign bit_tick  = (cnt_q == CW'(N - 1));

  // Start sample lands at cycle H; restarting the counter there puts every
  // later sample at H + k*N.
  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_clr = 1'b1;
        end
      end
      START: begin
        if (half_tick) begin
          cnt_clr = 1'b1;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_en = 1'b1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (rx_s) begin
            stop_ok = 1'b1;
            state_d = IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m        <= 1'b1;
      rx_s        <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_m    <= rx;
      rx_s    <= rx_m;
      state_q <= state_d;

      if (cnt_clr || bit_tick || state_q == IDLE || state_q == BREAK)
        cnt_q <= '0;
      else
        cnt_q <= cnt_q + 1'b1;

      if (state_q == START)
        bit_idx_q <= '0;
      else if (shift_en)
        bit_idx_q <= bit_idx_q + 3'd1;

      if (shift_en)
        shift_q <= {rx_s, shift_q[7:1]};

      frame_err_q <= stop_bad;
      overrun_q   <= stop_ok && valid_q && !out.rx_ready;

      // A full buffer that is being drained this cycle can take the new byte.
      if (stop_ok && (!valid_q || out.rx_ready)) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
      end else if (valid_q && out.rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out.rx_data   = data_q;
  assign out.rx_valid  = valid_q;
  assign out.frame_err = frame_err_q;
  assign out.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx against a frame-level model
module tb_uart_rx;

  localparam int NB = 69;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;

  uart_rx_if bus();

  uart_rx #(.F(8000000), .BAUD(115200)) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .out   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference model: one entry per frame at the byte level
  logic [7:0] exp_q[$];
  int exp_fe = 0;
  int exp_ov = 0;

  // Observations
  logic [7:0] got_q[$];
  int cyc = 0;
  int fe_cnt = 0, ov_cnt = 0;
  int pulse_viol = 0, both_viol = 0, hold_viol = 0;
  int last_rise = 0, vlen = 0, last_vlen = 0;
  logic fe_p = 0, ov_p = 0, v_p = 0, acc_p = 0;
  logic [7:0] d_p = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      v_p = 0; acc_p = 0; fe_p = 0; ov_p = 0; vlen = 0;
    end else begin
      if (bus.rx_valid && bus.rx_ready) got_q.push_back(bus.rx_data);
      if (bus.frame_err) fe_cnt++;
      if (bus.overrun) ov_cnt++;
      if ((bus.frame_err && fe_p) || (bus.overrun && ov_p)) pulse_viol++;
      if (bus.frame_err && bus.overrun) both_viol++;
      if (v_p && !acc_p && (!bus.rx_valid || bus.rx_data !== d_p)) hold_viol++;
      if (bus.rx_valid && !v_p) last_rise = cyc;
      if (bus.rx_valid) vlen++;
      else if (v_p) begin last_vlen = vlen; vlen = 0; end
      v_p = bus.rx_valid;
      acc_p = bus.rx_valid && bus.rx_ready;
      d_p = bus.rx_data;
      fe_p = bus.frame_err;
      ov_p = bus.overrun;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_bit(input logic v, input int p);
    step();
    rx = v;
    repeat (p - 1) @(posedge clk);
  endtask

  task automatic idle_clks(input int n);
    if (n > 0) drive_bit(1'b1, n);
  endtask

  int t_start = 0;

  task automatic send_frame(input logic [7:0] b, input int p, input logic stop_bit);
    step();
    rx = 1'b0;
    t_start = cyc;
    repeat (p - 1) @(posedge clk);
    for (int i = 0; i < 8; i++) drive_bit(b[i], p);
    drive_bit(stop_bit, p);
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop_ok);
    if (stop_ok) exp_q.push_back(b);
    else exp_fe++;
  endtask

  task automatic check_stream(input string tag);
    int n;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_byte"}, got_q[i], exp_q[i]);
    chk({tag, "_frame_err"}, fe_cnt, exp_fe);
    chk({tag, "_overrun"}, ov_cnt, exp_ov);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] pat [3];
    int p, lat;
    logic ok;
    pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h5A;
    bus.rx_ready = 1'b1;

    repeat (3) step();
    @(negedge clk);
    chk("reset_valid", bus.rx_valid, 0);
    chk("reset_data", bus.rx_data, 0);
    chk("reset_frame_err", bus.frame_err, 0);
    chk("reset_overrun", bus.overrun, 0);
    step();
    reset = 1'b0;
    idle_clks(2 * NB);

    // Single byte, latency and pulse width
    send_frame(8'hA5, NB, 1'b1);
    model_frame(8'hA5, 1'b1);
    lat = last_rise - t_start;
    idle_clks(2 * NB);
    chk($sformatf("a5_latency=%0d_within_656_659", lat), int'(lat >= 656 && lat <= 659), 1);
    chk("a5_valid_width", last_vlen, 1);
    check_stream("a5");

    // Overrun with consumer stalled
    step();
    bus.rx_ready = 1'b0;
    send_frame(8'h3C, NB, 1'b1);
    send_frame(8'hC3, NB, 1'b1);
    exp_ov++;
    idle_clks(NB);
    @(negedge clk);
    chk("ovr_valid_held", bus.rx_valid, 1);
    chk("ovr_data_kept", bus.rx_data, 8'h3C);
    step();
    bus.rx_ready = 1'b1;
    exp_q.push_back(8'h3C);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ovr_valid_dropped", bus.rx_valid, 0);
    check_stream("ovr");

    // Framing error followed by a held break
    send_frame(8'h55, NB, 1'b0);
    model_frame(8'h55, 1'b0);
    drive_bit(1'b0, 20 * NB);
    idle_clks(2 * NB);
    send_frame(8'h81, NB, 1'b1);
    model_frame(8'h81, 1'b1);
    idle_clks(2 * NB);
    check_stream("brk");

    // Short glitch in idle
    drive_bit(1'b0, 10);
    idle_clks(2 * NB);
    @(negedge clk);
    chk("glitch_valid", bus.rx_valid, 0);
    check_stream("glitch_quiet");
    send_frame(8'h0F, NB, 1'b1);
    model_frame(8'h0F, 1'b1);
    idle_clks(2 * NB);
    check_stream("glitch");

    // Baud mismatch sweep, back-to-back frames
    for (int s = 0; s < 2; s++) begin
      p = (s == 0) ? 66 : 72;
      for (int i = 0; i < 3; i++) begin
        send_frame(pat[i], p, 1'b1);
        model_frame(pat[i], 1'b1);
      end
      idle_clks(2 * NB);
      check_stream($sformatf("sweep%0d", p));
    end

    // Randomized frames
    for (int k = 0; k < 12; k++) begin
      b = 8'($urandom);
      p = $urandom_range(66, 72);
      ok = ($urandom_range(0, 4) != 0);
      send_frame(b, p, ok);
      model_frame(b, ok);
      if (!ok) idle_clks(NB);
      else idle_clks($urandom_range(0, NB));
    end
    idle_clks(2 * NB);
    check_stream("rand");

    // Reset in the middle of the 4th data bit with a byte still held
    step();
    bus.rx_ready = 1'b0;
    send_frame(8'($urandom), NB, 1'b1);
    idle_clks(NB);
    @(negedge clk);
    chk("rst_prehold_valid", bus.rx_valid, 1);
    b = 8'hF8 | 8'($urandom_range(0, 7));
    drive_bit(1'b0, NB);
    for (int i = 0; i < 3; i++) drive_bit(b[i], NB);
    step();
    rx = b[3];
    repeat (30) @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_valid", bus.rx_valid, 0);
    chk("rst_data", bus.rx_data, 0);
    chk("rst_frame_err", bus.frame_err, 0);
    chk("rst_overrun", bus.overrun, 0);
    step();
    reset = 1'b0;
    bus.rx_ready = 1'b1;
    repeat (35) @(posedge clk);
    for (int i = 4; i < 8; i++) drive_bit(b[i], NB);
    drive_bit(1'b1, NB);
    idle_clks(2 * NB);
    send_frame(8'hE7, NB, 1'b1);
    model_frame(8'hE7, 1'b1);
    idle_clks(2 * NB);
    check_stream("rst");

    chk("pulse_width_violations", pulse_viol, 0);
    chk("err_and_overrun_together", both_viol, 0);
    chk("held_byte_changed", hold_viol, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver: LSB first, 1 start bit, 8 data bits, 1 stop bit, no parity.
- Deserialises the asynchronous rx line into bytes and presents them on a valid/ready output stream.
- Counterpart of the existing UART transmitter. Sits between the board rx pin and the byte consumer (command parser / FIFO).
- Bit timing is derived from the system clock by an integer divider, with the same rounding as the transmitter so both ends agree.

Parameters:
- F, 8000000: system clock frequency in Hz.
- BAUD, 115200: line baud rate. Bit period N = (F+BAUD/2)/BAUD clocks (69 at defaults). Half period H = N/2, integer division (34 at defaults). Elaboration must fail if N < 4.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line; idle high.
- rx_data  output  8  received byte; stable while rx_valid=1.
- rx_valid  output  1  byte available; held until accepted.
- rx_ready  input  1  consumer accepts rx_data when rx_valid & rx_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte completed while buffer full, new byte dropped.

Behaviour:
- Synchroniser: two flops on rx; both reset to 1. All logic uses the second flop output rx_s only.
- Reset values: rx_valid=0, frame_err=0, overrun=0, rx_data=0, state=IDLE, counters=0.
- Reset mid-frame aborts the frame with no pulse and returns to IDLE; the partially received byte is discarded.
- Bit counter: counts 0..N-1 and wraps. Bit index counter: 0..7.
- State IDLE:
  - On rx_s=0 -> START; bit counter cleared. This edge is "cycle 0".
- State START:
  - At cycle H, sample rx_s.
  - rx_s=0 -> DATA; bit counter restarts so subsequent samples fall at H+k*N.
  - rx_s=1 (glitch) -> IDLE; no pulse.
- State DATA:
  - Sample rx_s at H+N*(i+1), i=0..7, into shift register bit i (LSB first).
  - After the 8th sample -> STOP.
- State STOP:
  - Sample rx_s at H+9N.
  - rx_s=1: byte complete -> delivery (below); -> IDLE.
  - rx_s=0: frame_err=1 for exactly one cycle, byte discarded, -> BREAK.
- State BREAK:
  - Wait for rx_s=1, then -> IDLE. This prevents a held-low line (break) from being read as repeated 0x00 frames.
- Delivery, evaluated in the cycle of the stop sample with rx_s=1:
  - rx_valid=0, or rx_valid=1 and rx_ready=1 in that cycle: rx_data <= new byte; rx_valid=1 next cycle; no overrun.
  - rx_valid=1 and rx_ready=0: old byte kept unchanged; overrun=1 for one cycle next cycle; new byte lost.
- Handshake:
  - rx_valid drops the cycle after rx_valid & rx_ready, unless a new byte is loaded in that same cycle.
  - rx_data must not change while rx_valid=1 and not accepted.
- Latency: rx_valid rises on the cycle after the stop sample, i.e. H+9N+1 clocks after cycle 0. rx pin to cycle 0 adds 2-3 clocks of synchroniser delay.
- Back-to-back frames:
  - Return to IDLE happens at mid-stop-bit, so a start edge arriving 0.5 bit later is caught.
  - Tolerates about ±4% baud mismatch.
- frame_err and overrun are never asserted in the same cycle. Each is exactly one cycle wide per event.

Test Plan:
- Defaults (N=69, H=34), rx_ready=1, send 0xA5 at exact baud -> rx_valid pulses one cycle with rx_data=0xA5. Rise occurs 34+621+1=656 clocks after cycle 0 (±3 clocks from the rx pin edge). frame_err=0, overrun=0.
- rx_ready=0, send 0x3C then 0xC3 back-to-back:
  - 0x3C is held with rx_valid=1.
  - At the end of 0xC3, overrun pulses once; rx_data stays 0x3C.
  - Then set rx_ready=1 -> one transfer of 0x3C, rx_valid drops.
- Send 0x55 with stop bit driven low -> frame_err one-cycle pulse, no rx_valid. Hold rx low 20 bit times -> no further frames and no further pulses. Release high, send 0x81 -> delivered 0x81.
- Drive rx low for 10 clocks (< H) in IDLE -> returns to IDLE, no output activity. A following frame 0x0F is received correctly.
- Sweep baud error: transmit 0x00, 0xFF, 0x5A with bit period 66 and 72 clocks -> all bytes received correctly, no errors.
- Assert reset during the 4th data bit of a frame -> outputs 0 next cycle. Deassert while the line is still mid-frame, then send a clean 0xE7 after idle -> only 0xE7 delivered (leftover bits may at most cause frame_err, never a false byte equal to the aborted frame).
